// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the DSP systolic array datapath: operand word and the
// state encoding of the west-edge skew feeder.
package dsp_sys_arr_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } feed_state_t;

endpackage

// File: rtl/sys_arr_skew_feeder_skew_window.sv
// Row-window comparator: row ROW wants an element on wavefront step cyc when
// ROW <= cyc < ROW + len_q. The compare width CW carries enough headroom that
// ROW + len_q can never wrap.
module skew_window #(
    parameter int KW  = 5,
    parameter int CW  = 8,
    parameter int ROW = 0
) (
    input  logic [CW-1:0] cyc,
    input  logic [KW-1:0] len_q,
    output logic          need
);

    localparam logic [CW-1:0] ROW_C = CW'(ROW);

    logic [CW-1:0] win_end;

    assign win_end = ROW_C + CW'(len_q);
    assign need    = (cyc >= ROW_C) && (cyc < win_end);

endmodule

// File: rtl/sys_arr_skew_feeder.sv
// West-edge feeder for the systolic array. Pops the per-row operand FIFOs as a
// diagonal wavefront (row r lags row 0 by r cycles), freezes the whole
// wavefront while any row that needs data is empty, and presents registered,
// zero-padded operands with per-row valid to the array.
module sys_arr_skew_feeder
    import dsp_sys_arr_pkg::*;
#(
    parameter  int ROWS  = 4,
    parameter  int DEPTH = 16,
    localparam int KW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    input  word_t [ROWS-1:0]    fifo_dat,
    input  logic [ROWS-1:0]     fifo_empty,
    output logic [ROWS-1:0]     fifo_pop,
    output word_t [ROWS-1:0]    arr_dat,
    output logic [ROWS-1:0]     arr_vld,
    output logic                busy,
    output logic                done
);

    // Step counter must reach len_q + ROWS - 1 without wrapping.
    localparam int CW = KW + $clog2(ROWS) + 1;

    feed_state_t     state;
    feed_state_t     state_nxt;
    logic [CW-1:0]   cyc;
    logic [CW-1:0]   cyc_nxt;
    logic [KW-1:0]   len_q;
    logic [KW-1:0]   len_nxt;
    logic [CW-1:0]   last_cyc;
    logic [ROWS-1:0] need;
    logic            stall;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_window #(
            .KW  (KW),
            .CW  (CW),
            .ROW (r)
        ) u_win (
            .cyc   (cyc),
            .len_q (len_q),
            .need  (need[r])
        );
    end

    // Only rows inside their window can stall the wavefront.
    assign stall    = |(need & fifo_empty);
    // Final wavefront step: the last row takes its last element here.
    assign last_cyc = CW'(len_q) + CW'(ROWS) - CW'(2);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Control registers: state, wavefront step and latched pass length.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cyc   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            len_q <= len_nxt;
        end
    end

    // Next-state, step advance and pop strobes; pops are suppressed on stall.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        len_nxt   = len_q;
        fifo_pop  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    len_nxt   = k_len;
                    cyc_nxt   = '0;
                    state_nxt = (k_len != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (!stall) begin
                    fifo_pop = need;
                    cyc_nxt  = cyc + CW'(1);
                    if (cyc == last_cyc) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand register: popped word goes to the array one cycle later, else zero.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            arr_dat <= '0;
            arr_vld <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                arr_dat[r] <= fifo_pop[r] ? fifo_dat[r] : '0;
            end
            arr_vld <= fifo_pop;
        end
    end

endmodule

// File: tb/tb_sys_arr_skew_feeder.sv
// Self-checking bench for sys_arr_skew_feeder: FIFO environment, wavefront
// reference model, per-cycle compare process, directed and random passes.
module tb_sys_arr_skew_feeder;
    import dsp_sys_arr_pkg::*;

    localparam int ROWS  = 4;
    localparam int DEPTH = 16;
    localparam int KW    = $clog2(DEPTH) + 1;

    logic                clk;
    logic                nRST;
    logic                start;
    logic [KW-1:0]       k_len;
    word_t [ROWS-1:0]    fifo_dat;
    logic [ROWS-1:0]     fifo_empty;
    logic [ROWS-1:0]     fifo_pop;
    word_t [ROWS-1:0]    arr_dat;
    logic [ROWS-1:0]     arr_vld;
    logic                busy;
    logic                done;

    sys_arr_skew_feeder #(.ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .start      (start),
        .k_len      (k_len),
        .fifo_dat   (fifo_dat),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .arr_dat    (arr_dat),
        .arr_vld    (arr_vld),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- FIFO environment ----------------
    word_t mem [ROWS][32];
    int    rd [ROWS];
    int    wr [ROWS];
    int    empty_until [ROWS];
    int    stall_pct = 0;
    int    gcyc = 0;
    logic [ROWS-1:0] pop_seen = '0;

    task automatic drive_fifos();
        for (int r = 0; r < ROWS; r++) begin
            logic hold;
            hold = (gcyc < empty_until[r]) || (int'($urandom_range(0, 99)) < stall_pct);
            fifo_empty[r] = (rd[r] >= wr[r]) || hold;
            fifo_dat[r]   = (rd[r] < wr[r]) ? mem[r][rd[r]] : word_t'($urandom);
        end
    endtask

    task automatic load(input int n, input bit rnd);
        for (int r = 0; r < ROWS; r++) begin
            rd[r] = 0;
            wr[r] = n;
            empty_until[r] = 0;
            for (int i = 0; i < n; i++)
                mem[r][i] = rnd ? word_t'($urandom) : word_t'(r * 16 + i + 1);
        end
        drive_fifos();
    endtask

    // Advance one clock; retire the words the DUT popped in the previous cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        gcyc++;
        for (int r = 0; r < ROWS; r++)
            if (pop_seen[r] && rd[r] < wr[r]) rd[r]++;
        drive_fifos();
    endtask

    // ---------------- reference model + compare ----------------
    // A pass is a sequence of wavefront steps t = 0 .. len+ROWS-2; step t hands
    // element (t - r) to row r when 0 <= t-r < len. A step only completes when
    // every row owed an element has one available. The cycle after the last
    // step reports done; a zero-length pass reports done at once.
    bit              m_active = 0;
    int              m_t, m_len, m_total;
    logic [ROWS-1:0] m_prev_vld = '0;
    word_t [ROWS-1:0] m_prev_dat = '0;
    logic [ROWS-1:0] e_pop;
    logic [ROWS-1:0] inwin;
    logic            e_busy, e_done, e_stall;

    always @(negedge clk) begin
        if (!nRST) begin
            chk("rst_pop",  fifo_pop, '0);
            chk("rst_vld",  arr_vld,  '0);
            chk("rst_dat",  arr_dat,  '0);
            chk("rst_busy", busy,     '0);
            chk("rst_done", done,     '0);
            m_active   = 0;
            m_prev_vld = '0;
            m_prev_dat = '0;
            pop_seen   = '0;
        end else begin
            e_pop = '0; e_busy = 0; e_done = 0; e_stall = 0;
            if (m_active && m_t < m_total) begin
                e_busy = 1;
                for (int r = 0; r < ROWS; r++) begin
                    inwin[r] = (m_t - r >= 0) && (m_t - r < m_len);
                    if (inwin[r] && fifo_empty[r]) e_stall = 1;
                end
                if (!e_stall) e_pop = inwin;
            end else if (m_active) begin
                e_busy = 1;
                e_done = 1;
            end
            chk("pop",          fifo_pop, e_pop);
            chk("busy",         busy,     e_busy);
            chk("done",         done,     e_done);
            chk("arr_vld",      arr_vld,  m_prev_vld);
            chk("arr_dat",      arr_dat,  m_prev_dat);
            chk("pop_on_empty", fifo_pop & fifo_empty, '0);
            pop_seen   = fifo_pop;
            m_prev_vld = e_pop;
            for (int r = 0; r < ROWS; r++)
                m_prev_dat[r] = e_pop[r] ? fifo_dat[r] : '0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_t      = 0;
                    m_len    = int'(k_len);
                    m_total  = (m_len == 0) ? 0 : m_len + ROWS - 1;
                end
            end else if (m_t < m_total) begin
                if (!e_stall) m_t++;
            end else begin
                m_active = 0;
            end
        end
    end

    always @(posedge clk)
        if (nRST && start && !busy)
            assert (k_len <= KW'(DEPTH)) else $error("illegal k_len %0d accepted", k_len);

    // ---------------- snapshots for literal expectations ----------------
    logic [ROWS-1:0]  s_pop  [64];
    logic [ROWS-1:0]  s_vld  [64];
    word_t [ROWS-1:0] s_dat  [64];
    logic             s_done [64];
    logic             s_busy [64];

    // Cycle 0 is the cycle start is driven in; hold keeps start high throughout.
    task automatic run(input int n, input bit hold);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s_pop[c] = fifo_pop; s_vld[c] = arr_vld; s_dat[c] = arr_dat;
            s_done[c] = done;    s_busy[c] = busy;
            tick();
            if (hold) k_len = KW'($urandom_range(1, 4));
            else      start = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) break;
            tick();
        end
        chk("idle_in_budget", k < budget, 1'b1);
        tick();
    endtask

    task automatic begin_pass(input int len);
        k_len = KW'(len);
        start = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt3;
        nRST = 1'b0; start = 1'b0; k_len = '0;
        load(0, 0);
        repeat (3) tick();
        nRST = 1'b1;

        // Basic wavefront, k_len=3.
        load(3, 0); begin_pass(3); run(10, 0);
        chk("t1_pop0_c1",  s_pop[1][0], 1'b1);
        chk("t1_pop0_c4",  s_pop[4][0], 1'b0);
        chk("t1_pop3_c3",  s_pop[3][3], 1'b0);
        chk("t1_pop3_c4",  s_pop[4][3], 1'b1);
        chk("t1_pop3_c6",  s_pop[6][3], 1'b1);
        chk("t1_dat0_c2",  s_dat[2][0], 16'd1);
        chk("t1_dat0_c4",  s_dat[4][0], 16'd3);
        chk("t1_vld0_c5",  s_vld[5][0], 1'b0);
        chk("t1_dat3_c5",  s_dat[5][3], 16'd49);
        chk("t1_dat3_c7",  s_dat[7][3], 16'd51);
        chk("t1_done_c6",  s_done[6],   1'b0);
        chk("t1_done_c7",  s_done[7],   1'b1);

        // Row 2 empty until cycle 4: one-cycle stall.
        load(3, 0); empty_until[2] = gcyc + 4; drive_fifos();
        begin_pass(3); run(11, 0);
        chk("t2_pop_c3",   s_pop[3],    4'b0000);
        chk("t2_pop_c4",   s_pop[4],    4'b0111);
        chk("t2_done_c7",  s_done[7],   1'b0);
        chk("t2_done_c8",  s_done[8],   1'b1);
        chk("t2_dat3_c8",  s_dat[8][3], 16'd51);

        // Zero-length pass.
        load(2, 0); begin_pass(0); run(4, 0);
        chk("t3_done_c1",  s_done[1],   1'b1);
        chk("t3_busy_c1",  s_busy[1],   1'b1);
        chk("t3_busy_c2",  s_busy[2],   1'b0);

        // start held high; k_len wanders after acceptance.
        load(8, 0); begin_pass(2); run(12, 1);
        start = 1'b0;
        wait_idle(100);
        for (int r = 0; r < ROWS; r++) begin
            cnt0 = 0;
            for (int c = 0; c <= 6; c++) cnt0 += int'(s_pop[c][r]);
            chk($sformatf("t4_pops_row%0d", r), cnt0, 2);
        end
        chk("t4_busy_c7",  s_busy[7],   1'b0);
        chk("t4_busy_c8",  s_busy[8],   1'b1);

        // Reset in the middle of a k_len=4 pass, then a k_len=1 pass.
        load(8, 0); begin_pass(4); run(3, 0);
        nRST = 1'b0;
        #1;
        chk("t5_async_pop",  fifo_pop, '0);
        chk("t5_async_vld",  arr_vld,  '0);
        chk("t5_async_dat",  arr_dat,  '0);
        chk("t5_async_busy", busy,     1'b0);
        tick(); tick();
        nRST = 1'b1;
        load(1, 0); begin_pass(1); run(8, 0);
        chk("t5_done_c5",  s_done[5],   1'b1);
        chk("t5_dat3_c5",  s_dat[5][3], 16'd49);

        // Full-depth pass.
        load(16, 0); begin_pass(16); run(23, 0);
        cnt0 = 0; cnt3 = 0;
        for (int c = 0; c < 23; c++) begin
            cnt0 += int'(s_pop[c][0]);
            cnt3 += int'(s_pop[c][3]);
        end
        chk("t6_pops_row0", cnt0, 16);
        chk("t6_pops_row3", cnt3, 16);
        chk("t6_done_c19",  s_done[19],   1'b0);
        chk("t6_done_c20",  s_done[20],   1'b1);
        chk("t6_vld3_c20",  s_vld[20][3], 1'b1);
        chk("t6_dat3_c20",  s_dat[20][3], 16'd64);

        // Random passes with random FIFO starvation.
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(0, DEPTH);
            stall_pct = $urandom_range(0, 30);
            load(len + $urandom_range(0, 3), 1);
            begin_pass(len);
            tick();
            k_len = KW'($urandom_range(0, DEPTH));
            start = ($urandom_range(0, 1) == 1);
            tick();
            start = 1'b0;
            wait_idle(400);
        end
        stall_pct = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
